reorder_buffer: RTL and testbench

- In-order retirement stage of the Tomasulo core, directly upstream of the register file.
- Allocates one entry per dispatched instruction in program order and captures functional-unit results by tag.
- Retires completed entries from the head in order, driving the register file's commit port (should-commit, value, index) one entry per cycle.
- Supplies dispatch with allocation tags, full/occupancy status and result forwarding for in-flight producers.

---
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 tb/tb_reorder_buffer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates entries in program order, captures FU results by tag,
// and retires completed head entries one per cycle onto the register file commit port.
module reorder_buffer #(
   parameter int DEPTH     = 16,
   parameter int DATA_W    = 64,
   parameter int REG_IDX_W = 5,
   parameter int TAG_W     = $clog2(DEPTH),
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   input  logic                 in_d_alloc_valid,
   input  logic                 in_d_has_dst,
   input  logic [REG_IDX_W-1:0] in_d_dst_reg,
   output logic                 out_d_alloc_ready,
   output logic [TAG_W-1:0]     out_d_alloc_tag,
   input  logic [TAG_W-1:0]     in_d_q1_tag,
   input  logic [TAG_W-1:0]     in_d_q2_tag,
   output logic                 out_d_q1_ready,
   output logic                 out_d_q2_ready,
   output logic [DATA_W-1:0]    out_d_q1_value,
   output logic [DATA_W-1:0]    out_d_q2_value,
   input  logic                 in_fu_done_valid,
   input  logic [TAG_W-1:0]     in_fu_done_tag,
   input  logic [DATA_W-1:0]    in_fu_done_value,
   input  logic                 in_flush,
   output logic                 out_regfile_should_commit,
   output logic [DATA_W-1:0]    out_regfile_commit_value,
   output logic [REG_IDX_W-1:0] out_regfile_index,
   output logic [CNT_W-1:0]     out_count
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     done_q, done_d;
   logic [DEPTH-1:0]     has_dst_q, has_dst_d;
   logic [REG_IDX_W-1:0] dst_reg_q [DEPTH];
   logic [REG_IDX_W-1:0] dst_reg_d [DEPTH];
   logic [DATA_W-1:0]    value_q [DEPTH];
   logic [DATA_W-1:0]    value_d [DEPTH];
   logic [TAG_W-1:0]     head_q, head_d;
   logic [TAG_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 should_commit_q, should_commit_d;
   logic [DATA_W-1:0]    commit_value_q, commit_value_d;
   logic [REG_IDX_W-1:0] commit_index_q, commit_index_d;
   logic                 do_alloc;
   logic                 do_retire;

   // Ready comes from registered count only, so a same-cycle retire never frees a slot.
   assign out_d_alloc_ready = (count_q != FULL_CNT);
   assign out_d_alloc_tag   = tail_q;
   assign out_count         = count_q;
   assign do_alloc          = in_d_alloc_valid && out_d_alloc_ready;
   assign do_retire         = valid_q[head_q] && done_q[head_q];

   assign out_d_q1_ready = valid_q[in_d_q1_tag] && done_q[in_d_q1_tag];
   assign out_d_q2_ready = valid_q[in_d_q2_tag] && done_q[in_d_q2_tag];
   assign out_d_q1_value = out_d_q1_ready ? value_q[in_d_q1_tag] : '0;
   assign out_d_q2_value = out_d_q2_ready ? value_q[in_d_q2_tag] : '0;

   assign out_regfile_should_commit = should_commit_q;
   assign out_regfile_commit_value  = commit_value_q;
   assign out_regfile_index         = commit_index_q;

   always_comb begin
      valid_d         = valid_q;
      done_d          = done_q;
      has_dst_d       = has_dst_q;
      dst_reg_d       = dst_reg_q;
      value_d         = value_q;
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      should_commit_d = 1'b0;
      commit_value_d  = '0;
      commit_index_d  = '0;

      if (in_fu_done_valid && valid_q[in_fu_done_tag]) begin
         done_d[in_fu_done_tag]  = 1'b1;
         value_d[in_fu_done_tag] = in_fu_done_value;
      end

      // Retire decision uses registered done, so a same-cycle writeback to the head waits a cycle.
      if (do_retire) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
         should_commit_d = has_dst_q[head_q];
         commit_value_d  = value_q[head_q];
         commit_index_d  = dst_reg_q[head_q];
      end

      if (do_alloc) begin
         valid_d[tail_q]   = 1'b1;
         done_d[tail_q]    = 1'b0;
         has_dst_d[tail_q] = in_d_has_dst;
         dst_reg_d[tail_q] = in_d_dst_reg;
         tail_d            = tail_q + 1'b1;
      end

      case ({do_alloc, do_retire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (in_flush) begin
         valid_d         = '0;
         head_d          = '0;
         tail_d          = '0;
         count_d         = '0;
         should_commit_d = 1'b0;
         commit_value_d  = '0;
         commit_index_d  = '0;
      end
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         valid_q         <= '0;
         done_q          <= '0;
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         should_commit_q <= 1'b0;
         commit_value_q  <= '0;
         commit_index_q  <= '0;
      end else begin
         valid_q         <= valid_d;
         done_q          <= done_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         should_commit_q <= should_commit_d;
         commit_value_q  <= commit_value_d;
         commit_index_q  <= commit_index_d;
      end
   end

   // Payload fields are only observed behind valid/done, so they carry no reset.
   always_ff @(posedge in_clk) begin
      has_dst_q <= has_dst_d;
      dst_reg_q <= dst_reg_d;
      value_q   <= value_d;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scenario tasks with inline checks plus a commit
// scoreboard that pops {index, value} expectations whenever a commit pulse appears.
module tb_reorder_buffer;

   localparam int DEPTH     = 16;
   localparam int DATA_W    = 64;
   localparam int REG_IDX_W = 5;
   localparam int TAG_W     = 4;
   localparam int CNT_W     = 5;
   localparam int EXP_W     = REG_IDX_W + DATA_W;

   logic                 clk = 1'b0;
   logic                 in_rst;
   logic                 in_d_alloc_valid;
   logic                 in_d_has_dst;
   logic [REG_IDX_W-1:0] in_d_dst_reg;
   logic                 out_d_alloc_ready;
   logic [TAG_W-1:0]     out_d_alloc_tag;
   logic [TAG_W-1:0]     in_d_q1_tag;
   logic [TAG_W-1:0]     in_d_q2_tag;
   logic                 out_d_q1_ready;
   logic                 out_d_q2_ready;
   logic [DATA_W-1:0]    out_d_q1_value;
   logic [DATA_W-1:0]    out_d_q2_value;
   logic                 in_fu_done_valid;
   logic [TAG_W-1:0]     in_fu_done_tag;
   logic [DATA_W-1:0]    in_fu_done_value;
   logic                 in_flush;
   logic                 out_regfile_should_commit;
   logic [DATA_W-1:0]    out_regfile_commit_value;
   logic [REG_IDX_W-1:0] out_regfile_index;
   logic [CNT_W-1:0]     out_count;

   int vecs = 0;
   int errs = 0;
   bit mon_en = 1'b0;
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] mon_exp;

   reorder_buffer #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .in_clk(clk),
      .in_rst(in_rst),
      .in_d_alloc_valid(in_d_alloc_valid),
      .in_d_has_dst(in_d_has_dst),
      .in_d_dst_reg(in_d_dst_reg),
      .out_d_alloc_ready(out_d_alloc_ready),
      .out_d_alloc_tag(out_d_alloc_tag),
      .in_d_q1_tag(in_d_q1_tag),
      .in_d_q2_tag(in_d_q2_tag),
      .out_d_q1_ready(out_d_q1_ready),
      .out_d_q2_ready(out_d_q2_ready),
      .out_d_q1_value(out_d_q1_value),
      .out_d_q2_value(out_d_q2_value),
      .in_fu_done_valid(in_fu_done_valid),
      .in_fu_done_tag(in_fu_done_tag),
      .in_fu_done_value(in_fu_done_value),
      .in_flush(in_flush),
      .out_regfile_should_commit(out_regfile_should_commit),
      .out_regfile_commit_value(out_regfile_commit_value),
      .out_regfile_index(out_regfile_index),
      .out_count(out_count)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   // Commit scoreboard: every commit pulse must match the oldest expectation
   always @(negedge clk) begin
      if (mon_en && out_regfile_should_commit) begin
         vecs++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL spurious_commit: got index=%0d value=%0h, required no commit",
                     out_regfile_index, out_regfile_commit_value);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({out_regfile_index, out_regfile_commit_value} !== mon_exp) begin
               errs++;
               $display("FAIL commit_data: got index=%0d value=%0h, required index=%0d value=%0h",
                        out_regfile_index, out_regfile_commit_value,
                        mon_exp[EXP_W-1 -: REG_IDX_W], mon_exp[DATA_W-1:0]);
            end
         end
      end
   end

   // Driver tasks
   task automatic step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      in_rst = 1'b0;
      @(negedge clk);
      in_rst = 1'b1;
   endtask

   task automatic drive_alloc(input logic hd, input logic [REG_IDX_W-1:0] r);
      in_d_alloc_valid = 1'b1;
      in_d_has_dst     = hd;
      in_d_dst_reg     = r;
      @(negedge clk);
      in_d_alloc_valid = 1'b0;
      in_d_has_dst     = 1'b0;
   endtask

   task automatic drive_wb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
      in_fu_done_valid = 1'b1;
      in_fu_done_tag   = t;
      in_fu_done_value = v;
      @(negedge clk);
      in_fu_done_valid = 1'b0;
   endtask

   // Scenarios
   task automatic test_reset();
      in_rst = 1'b0;
      repeat (2) @(negedge clk);
      vecs++;
      if ({out_d_alloc_ready, out_d_alloc_tag, out_count, out_regfile_should_commit,
           out_regfile_index, out_regfile_commit_value, out_d_q1_ready, out_d_q1_value} !==
          {1'b1, 4'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0}) begin
         errs++;
         $display("FAIL reset_outputs: got ready=%0b tag=%0d count=%0d sc=%0b idx=%0d val=%0h, required 1,0,0,0,0,0",
                  out_d_alloc_ready, out_d_alloc_tag, out_count, out_regfile_should_commit,
                  out_regfile_index, out_regfile_commit_value);
      end
      in_rst = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         vecs++;
         if ({out_d_alloc_ready, out_d_alloc_tag, out_count, out_regfile_should_commit} !==
             {1'b1, 4'd0, 5'd0, 1'b0}) begin
            errs++;
            $display("FAIL idle_state cycle %0d: got ready=%0b tag=%0d count=%0d sc=%0b, required 1,0,0,0",
                     i, out_d_alloc_ready, out_d_alloc_tag, out_count, out_regfile_should_commit);
         end
      end
   endtask

   task automatic test_single();
      apply_reset();
      drive_alloc(1'b1, 5'd3);
      vecs++;
      if (out_count !== 5'd1) begin errs++; $display("FAIL single_count_alloc: got %0d, required 1", out_count); end
      exp_q.push_back({5'd3, 64'h2A});
      drive_wb(4'd0, 64'h2A);
      vecs++;
      if (out_regfile_should_commit !== 1'b0) begin errs++; $display("FAIL single_early_commit: got %0b, required 0", out_regfile_should_commit); end
      step();
      vecs++;
      if ({out_regfile_should_commit, out_count} !== {1'b1, 5'd0}) begin
         errs++;
         $display("FAIL single_commit: got sc=%0b count=%0d, required sc=1 count=0", out_regfile_should_commit, out_count);
      end
      step();
      vecs++;
      if (out_regfile_should_commit !== 1'b0) begin errs++; $display("FAIL single_pulse_width: got %0b, required 0", out_regfile_should_commit); end
   endtask

   task automatic test_out_of_order();
      logic [REG_IDX_W-1:0] regs [3] = '{5'd1, 5'd2, 5'd4};
      logic [DATA_W-1:0]    vals [3] = '{64'h10, 64'h11, 64'h22};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if (out_d_alloc_tag !== TAG_W'(i)) begin errs++; $display("FAIL ooo_tag %0d: got %0d, required %0d", i, out_d_alloc_tag, i); end
         drive_alloc(1'b1, regs[i]);
         exp_q.push_back({regs[i], vals[i]});
      end
      drive_wb(4'd2, vals[2]);
      drive_wb(4'd0, vals[0]);
      vecs++;
      if (out_regfile_should_commit !== 1'b0) begin errs++; $display("FAIL ooo_early: got %0b, required 0", out_regfile_should_commit); end
      drive_wb(4'd1, vals[1]);
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if ({out_regfile_should_commit, out_regfile_index} !== {1'b1, regs[i]}) begin
            errs++;
            $display("FAIL ooo_order %0d: got sc=%0b idx=%0d, required sc=1 idx=%0d",
                     i, out_regfile_should_commit, out_regfile_index, regs[i]);
         end
         step();
      end
      vecs++;
      if ({out_regfile_should_commit, out_count} !== {1'b0, 5'd0}) begin
         errs++;
         $display("FAIL ooo_drain: got sc=%0b count=%0d, required 0,0", out_regfile_should_commit, out_count);
      end
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         vecs++;
         if ({out_d_alloc_ready, out_d_alloc_tag} !== {1'b1, TAG_W'(i)}) begin
            errs++;
            $display("FAIL fill_tag %0d: got ready=%0b tag=%0d, required ready=1 tag=%0d", i, out_d_alloc_ready, out_d_alloc_tag, i);
         end
         in_d_alloc_valid = 1'b1;
         in_d_has_dst     = 1'b1;
         in_d_dst_reg     = REG_IDX_W'(i);
         @(negedge clk);
      end
      vecs++;
      if ({out_d_alloc_ready, out_count, out_d_alloc_tag} !== {1'b0, 5'd16, 4'd0}) begin
         errs++;
         $display("FAIL full_state: got ready=%0b count=%0d tag=%0d, required 0,16,0", out_d_alloc_ready, out_count, out_d_alloc_tag);
      end
      in_d_dst_reg     = 5'd20;
      in_fu_done_valid = 1'b1;
      in_fu_done_tag   = 4'd0;
      in_fu_done_value = 64'hA0;
      exp_q.push_back({5'd0, 64'hA0});
      step();
      in_fu_done_valid = 1'b0;
      vecs++;
      if ({out_d_alloc_ready, out_count, out_regfile_should_commit} !== {1'b0, 5'd16, 1'b0}) begin
         errs++;
         $display("FAIL full_hold: got ready=%0b count=%0d sc=%0b, required 0,16,0", out_d_alloc_ready, out_count, out_regfile_should_commit);
      end
      step();
      vecs++;
      if ({out_d_alloc_ready, out_count, out_regfile_should_commit} !== {1'b1, 5'd15, 1'b1}) begin
         errs++;
         $display("FAIL full_retire_no_alloc: got ready=%0b count=%0d sc=%0b, required 1,15,1", out_d_alloc_ready, out_count, out_regfile_should_commit);
      end
      step();
      in_d_alloc_valid = 1'b0;
      vecs++;
      if ({out_d_alloc_ready, out_count, out_d_alloc_tag} !== {1'b0, 5'd16, 4'd1}) begin
         errs++;
         $display("FAIL full_realloc: got ready=%0b count=%0d tag=%0d, required 0,16,1", out_d_alloc_ready, out_count, out_d_alloc_tag);
      end
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] v;
      apply_reset();
      for (int k = 0; k < 20; k++) begin
         vecs++;
         if ({out_d_alloc_ready, out_d_alloc_tag} !== {1'b1, TAG_W'(k % DEPTH)}) begin
            errs++;
            $display("FAIL wrap_tag %0d: got ready=%0b tag=%0d, required ready=1 tag=%0d", k, out_d_alloc_ready, out_d_alloc_tag, k % DEPTH);
         end
         in_d_alloc_valid = 1'b1;
         in_d_has_dst     = 1'b1;
         in_d_dst_reg     = REG_IDX_W'(k);
         if (k > 0) begin
            v = DATA_W'(32'h1000 + $urandom_range(0, 255) * 32'h10000 + k - 1);
            in_fu_done_valid = 1'b1;
            in_fu_done_tag   = TAG_W'((k - 1) % DEPTH);
            in_fu_done_value = v;
            exp_q.push_back({REG_IDX_W'(k - 1), v});
         end
         @(negedge clk);
      end
      in_d_alloc_valid = 1'b0;
      in_fu_done_tag   = 4'd3;
      in_fu_done_value = 64'h1013;
      exp_q.push_back({5'd19, 64'h1013});
      step();
      in_fu_done_valid = 1'b0;
      repeat (3) step();
      vecs++;
      if ({out_count, out_d_alloc_tag} !== {5'd0, 4'd4}) begin
         errs++;
         $display("FAIL wrap_drain: got count=%0d tag=%0d, required 0,4", out_count, out_d_alloc_tag);
      end
   endtask

   task automatic test_no_dst_forward();
      apply_reset();
      drive_alloc(1'b0, 5'd9);
      drive_alloc(1'b1, 5'd5);
      drive_wb(4'd1, 64'd7);
      in_d_q1_tag = 4'd1;
      in_d_q2_tag = 4'd2;
      #1;
      vecs++;
      if ({out_d_q1_ready, out_d_q1_value} !== {1'b1, 64'd7}) begin
         errs++;
         $display("FAIL fwd_done: got ready=%0b value=%0h, required 1,7", out_d_q1_ready, out_d_q1_value);
      end
      vecs++;
      if ({out_d_q2_ready, out_d_q2_value} !== {1'b0, 64'd0}) begin
         errs++;
         $display("FAIL fwd_invalid: got ready=%0b value=%0h, required 0,0", out_d_q2_ready, out_d_q2_value);
      end
      in_d_q2_tag = 4'd0;
      #1;
      vecs++;
      if ({out_d_q2_ready, out_d_q2_value} !== {1'b0, 64'd0}) begin
         errs++;
         $display("FAIL fwd_not_done: got ready=%0b value=%0h, required 0,0", out_d_q2_ready, out_d_q2_value);
      end
      exp_q.push_back({5'd5, 64'd7});
      drive_wb(4'd0, 64'h55);
      step();
      vecs++;
      if ({out_count, out_regfile_should_commit} !== {5'd1, 1'b0}) begin
         errs++;
         $display("FAIL nodst_retire: got count=%0d sc=%0b, required 1,0", out_count, out_regfile_should_commit);
      end
      step();
      #1;
      vecs++;
      if ({out_count, out_regfile_should_commit, out_d_q1_ready, out_d_q1_value} !== {5'd0, 1'b1, 1'b0, 64'd0}) begin
         errs++;
         $display("FAIL nodst_next: got count=%0d sc=%0b q1_ready=%0b q1_value=%0h, required 0,1,0,0",
                  out_count, out_regfile_should_commit, out_d_q1_ready, out_d_q1_value);
      end
      step();
   endtask

   task automatic test_flush(input bit use_rst);
      apply_reset();
      for (int i = 0; i < 5; i++) drive_alloc(1'b1, REG_IDX_W'(10 + i));
      drive_wb(4'd2, 64'hB2);
      drive_wb(4'd0, 64'hB0);
      if (use_rst) in_rst = 1'b0;
      else in_flush = 1'b1;
      in_d_alloc_valid = 1'b1;
      in_d_has_dst     = 1'b1;
      in_d_dst_reg     = 5'd30;
      in_fu_done_valid = 1'b1;
      in_fu_done_tag   = 4'd3;
      in_fu_done_value = 64'hB3;
      step();
      in_rst           = 1'b1;
      in_flush         = 1'b0;
      in_d_alloc_valid = 1'b0;
      in_fu_done_valid = 1'b0;
      vecs++;
      if ({out_count, out_d_alloc_tag, out_d_alloc_ready, out_regfile_should_commit,
           out_regfile_index, out_regfile_commit_value} !== {5'd0, 4'd0, 1'b1, 1'b0, 5'd0, 64'd0}) begin
         errs++;
         $display("FAIL flush_state rst=%0b: got count=%0d tag=%0d ready=%0b sc=%0b idx=%0d val=%0h, required 0,0,1,0,0,0",
                  use_rst, out_count, out_d_alloc_tag, out_d_alloc_ready, out_regfile_should_commit,
                  out_regfile_index, out_regfile_commit_value);
      end
      drive_wb(4'd1, 64'hC1);
      drive_wb(4'd4, 64'hC4);
      repeat (2) step();
      in_d_q1_tag = 4'd1;
      in_d_q2_tag = 4'd0;
      #1;
      vecs++;
      if ({out_count, out_d_q1_ready, out_d_q2_ready} !== {5'd0, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL flush_stale_wb rst=%0b: got count=%0d q1_ready=%0b q2_ready=%0b, required 0,0,0",
                  use_rst, out_count, out_d_q1_ready, out_d_q2_ready);
      end
      drive_alloc(1'b1, 5'd7);
      #1;
      vecs++;
      if ({out_count, out_d_q2_ready} !== {5'd1, 1'b0}) begin
         errs++;
         $display("FAIL flush_realloc rst=%0b: got count=%0d q2_ready=%0b, required 1,0", use_rst, out_count, out_d_q2_ready);
      end
      exp_q.push_back({5'd7, 64'hD0});
      drive_wb(4'd0, 64'hD0);
      repeat (2) step();
      vecs++;
      if (out_count !== 5'd0) begin errs++; $display("FAIL flush_drain rst=%0b: got count=%0d, required 0", use_rst, out_count); end
   endtask

   initial begin
      in_rst           = 1'b0;
      in_d_alloc_valid = 1'b0;
      in_d_has_dst     = 1'b0;
      in_d_dst_reg     = '0;
      in_d_q1_tag      = '0;
      in_d_q2_tag      = '0;
      in_fu_done_valid = 1'b0;
      in_fu_done_tag   = '0;
      in_fu_done_value = '0;
      in_flush         = 1'b0;

      test_reset();
      test_single();
      test_out_of_order();
      test_full();
      test_wrap();
      test_no_dst_forward();
      test_flush(1'b0);
      test_flush(1'b1);

      step();
      vecs++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL scoreboard_leftover: got %0d pending commits, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
